// File: rtl/ram_sweep.sv
// ============================================================================
// Module   : ram_sweep
// Brief    : Parametrised single-port RAM with a hardware zero-sweep sequencer.
//            Define RAM_SWEEP_READ_REG_EN for a registered (read-first) output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_sweep #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_BITS-1:0] address,
  input  logic [WIDTH-1:0]     in,
  input  logic                 load,
  input  logic                 clear,
  output logic [WIDTH-1:0]     out,
  output logic                 busy,
  output logic                 clr_done
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] c_ptr_last = '1;
  localparam logic [ADDR_BITS-1:0] c_ptr_one  = 1;

  generate
    if (ADDR_BITS < 1) begin : g_addr_bits_check
      $error("ram_sweep: ADDR_BITS must be at least 1");
    end
  endgenerate

  typedef enum logic [0:0] {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [ADDR_BITS-1:0]   r_ptr;
  logic [ADDR_BITS-1:0]   w_ptr_next;
  logic                   r_busy;
  logic                   r_clr_done;
  logic                   w_clr_done_next;
  logic                   w_we;
  logic [ADDR_BITS-1:0]   w_waddr;
  logic [WIDTH-1:0]       w_wdata;
  logic [WIDTH-1:0]       r_mem [DEPTH];

  // The single write port is shared between the sweeper and the user path.
  always_comb begin
    w_state_next    = r_state;
    w_ptr_next      = r_ptr;
    w_clr_done_next = 1'b0;
    w_we            = 1'b0;
    w_waddr         = address;
    w_wdata         = in;
    case (r_state)
      SWEEP: begin
        w_we    = 1'b1;
        w_waddr = r_ptr;
        w_wdata = '0;
        if (r_ptr == c_ptr_last) begin
          w_ptr_next      = '0;
          w_state_next    = IDLE;
          w_clr_done_next = 1'b1;
        end else begin
          w_ptr_next = r_ptr + c_ptr_one;
        end
      end
      IDLE: begin
        if (clear) begin
          w_state_next = SWEEP;
          w_ptr_next   = '0;
        end else if (load) begin
          w_we = 1'b1;
        end
      end
      default: w_state_next = SWEEP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= SWEEP;
      r_ptr      <= '0;
      r_busy     <= 1'b1;
      r_clr_done <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ptr      <= w_ptr_next;
      r_busy     <= (w_state_next == SWEEP);
      r_clr_done <= w_clr_done_next;
    end
  end

  // Reset leaves the array alone; the sweep that follows zeros it.
  always_ff @(posedge clk) begin
    if (rst_n && w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

`ifdef RAM_SWEEP_READ_REG_EN
  logic [WIDTH-1:0] r_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out <= '0;
    end else begin
      r_out <= r_busy ? '0 : r_mem[address];
    end
  end

  assign out = r_out;
`else
  assign out = r_busy ? '0 : r_mem[address];
`endif

  assign busy     = r_busy;
  assign clr_done = r_clr_done;

endmodule

`default_nettype wire

// File: doc/ram_sweep.md
Name: ram_sweep

Overview:
- Parametrised single-port RAM; next generation of the fixed 64x16 RAM block.
- Same address/in/load/out contract, generalised in width and depth.
- Adds a hardware clear sequencer: a synchronous reset cannot zero a memory array in one cycle, so an FSM sweeps every word to zero after reset or on request.
- Sits under the CPU data path as the data/program store; `busy` gates the CPU/loader until contents are defined.

Parameters:
- WIDTH, 16, data word width in bits.
- ADDR_BITS, 6, address width. Local DEPTH = 2**ADDR_BITS words.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- address  input  ADDR_BITS  read/write word address.
- in  input  WIDTH  write data.
- load  input  1  write enable; honoured only when idle.
- clear  input  1  request a full zero sweep; honoured only when idle.
- out  output  WIDTH  read data.
- busy  output  1  high while a sweep is running.
- clr_done  output  1  one-cycle pulse when a sweep completes.

Behaviour:
- Reset edge (rst_n=0):
  - state=SWEEP, sweep pointer=0, busy=1, clr_done=0, out=0.
  - Array contents are untouched by reset itself; the sweep zeros them.
- FSM states: SWEEP, IDLE.
- SWEEP, each edge:
  - mem[ptr] <= 0.
  - If ptr==DEPTH-1: ptr<=0, state<=IDLE, clr_done<=1 for exactly that next cycle.
  - Otherwise ptr<=ptr+1.
  - A sweep takes exactly DEPTH edges. After reset deasserts, busy falls after the DEPTH-th edge.
- IDLE, each edge:
  - If clear=1: state<=SWEEP, ptr<=0, busy<=1. Any load in the same cycle is dropped; clear has priority.
  - Else if load=1: mem[address] <= in.
  - clr_done<=0.
- Ignored during SWEEP: load and clear. A clear held high through a sweep's end starts a new sweep on the first IDLE edge.
- Read (default build):
  - out = busy ? 0 : mem[address], combinational.
  - A write is visible on out immediately after the writing edge.
- busy = (state==SWEEP), registered.
- Pointer wrap: ptr never exceeds DEPTH-1; terminal compare uses ADDR_BITS-wide equality to all-ones.
- rst_n low mid-sweep or mid-idle: sweep restarts from 0 on the next edge with rst_n=1; a partial sweep is not resumed.
- DEPTH=1 (ADDR_BITS=0 is not supported): ADDR_BITS>=1 is required; synthesis/elaboration error otherwise.
- Width rules: no arithmetic on data; pointer increment is modulo DEPTH.

Optional Feature:
- Macro RAM_SWEEP_READ_REG_EN.
- Defined, registered read:
  - out <= busy ? 0 : mem[address] on every edge; one-cycle latency.
  - Read-first: a same-address write and read in one cycle returns the old word; the new word appears one edge later.
  - out reset to 0.
- Undefined: combinational read as above, zero latency.

Test Plan:
- Reset then sweep: rst_n=0 for 2 edges, then 1 -> busy=1 for exactly 64 edges; clr_done=1 on cycle 64 only; out=0 at every address afterwards.
- Write/read: idle, address=3, in=16'hBEEF, load=1 for one edge -> out=16'hBEEF at address 3 (same cycle after edge; next edge with READ_REG_EN); address 7 still reads 0.
- Corner addresses: write 16'h1234 at address 0 and 16'hFFFF at address 63 -> both read back; no alias at 32 or 1.
- Clear vs load: write 16'hAAAA at address 5; next cycle clear=1, load=1, address=6, in=16'h5555 -> busy=1, address 6 never written; after 64 edges address 5 reads 0, clr_done pulses.
- Load during sweep: busy=1, load=1, address=10, in=16'h0F0F -> after sweep, address 10 reads 0.
- Reset mid-sweep: rst_n=0 at sweep edge 20, release -> busy stays high a full 64 further edges; clr_done pulses once, at the end only.
